// File: rtl/rat_pkg.sv
// Purpose:      shared types and constants for the RAT MCU fetch path.
// Latency:      n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch_state_t phase encoding, PC_MUX_SEL codes, default vectors.
package rat_pkg;

  localparam int              ADDR_W_DEF    = 10;
  localparam logic [9:0]      RESET_VEC_DEF = 10'h000;
  localparam logic [9:0]      INTR_VEC_DEF  = 10'h3FF;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INTR  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PCSEL_IMMED = 2'd0;
  localparam logic [1:0] PCSEL_STACK = 2'd1;
  localparam logic [1:0] PCSEL_VEC   = 2'd2;
  localparam logic [1:0] PCSEL_HOLD  = 2'd3;

endpackage

// File: rtl/program_counter.sv
// Purpose:      program counter register with increment and 4:1 load-source mux.
// Latency:      1 cycle from clr/ld/inc to pc_count.
// Backpressure: none; the PC holds whenever no enable is active.
// Ports: CLK/RESET (sync, active-high); pc_clr forces RESET_VEC; pc_ld loads
//        the source chosen by pc_sel (PCSEL_HOLD suppresses the load); pc_inc
//        adds one; from_immed/from_stack are load sources; pc_count is the PC.
module program_counter
  import rat_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [ADDR_W-1:0] INTR_VEC  = INTR_VEC_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              pc_clr,
  input  logic              pc_ld,
  input  logic              pc_inc,
  input  logic [1:0]        pc_sel,
  input  logic [ADDR_W-1:0] from_immed,
  input  logic [ADDR_W-1:0] from_stack,
  output logic [ADDR_W-1:0] pc_count
);

  logic [ADDR_W-1:0] pc_src;
  logic              ld_en;

  always_comb begin
    pc_src = pc_count;
    case (pc_sel)
      PCSEL_IMMED: pc_src = from_immed;
      PCSEL_STACK: pc_src = from_stack;
      PCSEL_VEC:   pc_src = INTR_VEC;
      default:     pc_src = pc_count;
    endcase
  end

  // The hold code turns a load request into a no-op rather than a self-load,
  // so it also blocks an increment issued in the same cycle from being masked.
  assign ld_en = pc_ld && (pc_sel != PCSEL_HOLD);

  always_ff @(posedge CLK) begin
    if (RESET || pc_clr) begin
      pc_count <= RESET_VEC;
    end else if (ld_en) begin
      pc_count <= pc_src;
    end else if (pc_inc) begin
      // Natural wrap at 2^ADDR_W.
      pc_count <= pc_count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Purpose:      RAT MCU fetch sequencer: INIT/FETCH/EXEC/INTR phase FSM, PC, interrupt latch.
// Latency:      2 cycles per instruction (FETCH, EXEC), +1 cycle for interrupt entry.
// Backpressure: none; the machine free-runs, loads are honoured only in EXEC.
// Ports: CLK/RESET (sync, active-high); PC_LD, PC_MUX_SEL, FROM_IMMED,
//        FROM_STACK from the control unit; INTR, IE interrupt request/enable;
//        PC_COUNT drives the ROM address; STATE_FETCH, STATE_EXEC, INTR_ACK
//        decode the phase register; INTR_PEND is the latched request.
module fetch_unit
  import rat_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [ADDR_W-1:0] INTR_VEC  = INTR_VEC_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PC_LD,
  input  logic [1:0]        PC_MUX_SEL,
  input  logic [ADDR_W-1:0] FROM_IMMED,
  input  logic [ADDR_W-1:0] FROM_STACK,
  input  logic              INTR,
  input  logic              IE,
  output logic [ADDR_W-1:0] PC_COUNT,
  output logic              STATE_FETCH,
  output logic              STATE_EXEC,
  output logic              INTR_ACK,
  output logic              INTR_PEND
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic       pend;
  logic       pc_clr;
  logic       pc_ld;
  logic       pc_inc;
  logic [1:0] pc_sel;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_clr    = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_sel    = PC_MUX_SEL;
    case (state)
      ST_INIT: begin
        pc_clr    = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        pc_inc    = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        pc_ld = PC_LD;
        // INTR is looked at directly as well as through the latch so a
        // request arriving in the EXEC cycle itself is not delayed a whole
        // instruction.
        if ((pend || INTR) && IE) begin
          state_nxt = ST_INTR;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_INTR: begin
        pc_ld     = 1'b1;
        pc_sel    = PCSEL_VEC;
        state_nxt = ST_FETCH;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Pending latch is independent of IE so a masked request waits for IE.
  // The INTR cycle acknowledges it, so clearing wins over a same-cycle set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= 1'b0;
    end else if (state == ST_INIT || state == ST_INTR) begin
      pend <= 1'b0;
    end else if (INTR) begin
      pend <= 1'b1;
    end
  end

  program_counter #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RESET_VEC),
    .INTR_VEC  (INTR_VEC)
  ) u_pc (
    .CLK        (CLK),
    .RESET      (RESET),
    .pc_clr     (pc_clr),
    .pc_ld      (pc_ld),
    .pc_inc     (pc_inc),
    .pc_sel     (pc_sel),
    .from_immed (FROM_IMMED),
    .from_stack (FROM_STACK),
    .pc_count   (PC_COUNT)
  );

  assign STATE_FETCH = (state == ST_FETCH);
  assign STATE_EXEC  = (state == ST_EXEC);
  assign INTR_ACK    = (state == ST_INTR);
  assign INTR_PEND   = pend;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose:      directed, scoreboarded bench for fetch_unit.
// Latency:      one expectation per clock cycle, checked at the falling edge.
// Backpressure: n/a.
module tb_fetch_unit;

  typedef struct packed {
    logic [9:0] pc;
    logic       f;
    logic       e;
    logic       a;
    logic       p;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       PC_LD;
  logic [1:0] PC_MUX_SEL;
  logic [9:0] FROM_IMMED;
  logic [9:0] FROM_STACK;
  logic       INTR;
  logic       IE;
  logic [9:0] PC_COUNT;
  logic       STATE_FETCH;
  logic       STATE_EXEC;
  logic       INTR_ACK;
  logic       INTR_PEND;

  obs_t exp_q[$];
  int   id_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;
  bit   mon_en   = 1'b0;

  fetch_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC_LD       (PC_LD),
    .PC_MUX_SEL  (PC_MUX_SEL),
    .FROM_IMMED  (FROM_IMMED),
    .FROM_STACK  (FROM_STACK),
    .INTR        (INTR),
    .IE          (IE),
    .PC_COUNT    (PC_COUNT),
    .STATE_FETCH (STATE_FETCH),
    .STATE_EXEC  (STATE_EXEC),
    .INTR_ACK    (INTR_ACK),
    .INTR_PEND   (INTR_PEND)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, record what the outputs must show during that
  // cycle, then advance to just after the next rising edge.
  task automatic step(input logic rst, input logic ld, input logic [1:0] sel,
                      input logic [9:0] imm, input logic [9:0] stk,
                      input logic irq, input logic ie_i,
                      input logic [9:0] epc, input logic ef, input logic ee,
                      input logic ea, input logic ep);
    obs_t o;
    RESET      = rst;
    PC_LD      = ld;
    PC_MUX_SEL = sel;
    FROM_IMMED = imm;
    FROM_STACK = stk;
    INTR       = irq;
    IE         = ie_i;
    o.pc = epc; o.f = ef; o.e = ee; o.a = ea; o.p = ep;
    exp_q.push_back(o);
    id_q.push_back(vec_id);
    vec_id++;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so one pop per falling edge.
  initial begin
    obs_t got;
    obs_t exp;
    int   id;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        got = {PC_COUNT, STATE_FETCH, STATE_EXEC, INTR_ACK, INTR_PEND};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL underflow: DUT output pc=%h f%b e%b a%b p%b with no expectation queued",
                   got.pc, got.f, got.e, got.a, got.p);
        end else begin
          exp = exp_q.pop_front();
          id  = id_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL vec%0d: got pc=%h f%b e%b a%b p%b, expected pc=%h f%b e%b a%b p%b",
                     id, got.pc, got.f, got.e, got.a, got.p,
                     exp.pc, exp.f, exp.e, exp.a, exp.p);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; PC_LD = 1'b0; PC_MUX_SEL = 2'd0;
    FROM_IMMED = '0; FROM_STACK = '0; INTR = 1'b0; IE = 1'b0;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    //    rst ld sel  imm     stk     irq ie   pc      f e a p
    // Reset held, then free run: 0,0,1,1,2,2
    step(1, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0); // INIT
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h000, 1, 0, 0, 0); // FETCH
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h001, 0, 1, 0, 0); // EXEC
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h001, 1, 0, 0, 0);
    // EXEC load from immediate
    step(0, 1, 2'd0, 10'h155, 10'h000, 0, 0, 10'h002, 0, 1, 0, 0);
    // Load request in FETCH is ignored
    step(0, 1, 2'd1, 10'h155, 10'h2AA, 0, 0, 10'h155, 1, 0, 0, 0);
    // EXEC load from stack
    step(0, 1, 2'd1, 10'h155, 10'h2AA, 0, 0, 10'h156, 0, 1, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h2AA, 1, 0, 0, 0);
    // Hold code suppresses the load
    step(0, 1, 2'd3, 10'h155, 10'h2AA, 0, 0, 10'h2AB, 0, 1, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h2AB, 1, 0, 0, 0);
    // Load 3FF then fetch: wraps to 000
    step(0, 1, 2'd0, 10'h3FF, 10'h000, 0, 0, 10'h2AC, 0, 1, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h3FF, 1, 0, 0, 0);
    step(0, 1, 2'd0, 10'h01F, 10'h000, 0, 0, 10'h000, 0, 1, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h01F, 1, 0, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h020, 0, 1, 0, 0);
    // IE=1, INTR pulsed during FETCH at 020
    step(0, 0, 2'd0, 10'h000, 10'h000, 1, 1, 10'h020, 1, 0, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h021, 0, 1, 0, 1);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h021, 0, 0, 1, 1); // INTR
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h3FF, 1, 0, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h000, 0, 1, 0, 0);
    // IE=0: request stays pending, no entry
    step(0, 0, 2'd0, 10'h000, 10'h000, 1, 0, 10'h000, 1, 0, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h001, 0, 1, 0, 1);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 0, 10'h001, 1, 0, 0, 1);
    // IE rises: exactly one entry
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h002, 0, 1, 0, 1);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h002, 0, 0, 1, 1);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h3FF, 1, 0, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h000, 0, 1, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h000, 1, 0, 0, 0);
    // Load and interrupt together in EXEC: return address is the target
    step(0, 1, 2'd0, 10'h0AB, 10'h000, 1, 1, 10'h001, 0, 1, 0, 0);
    // PC_LD during INTR ignored; vector wins
    step(0, 1, 2'd0, 10'h155, 10'h000, 0, 1, 10'h0AB, 0, 0, 1, 1);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h3FF, 1, 0, 0, 0);
    // Software jump to vector: no ACK
    step(0, 1, 2'd2, 10'h000, 10'h000, 0, 1, 10'h000, 0, 1, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h3FF, 1, 0, 0, 0);
    // RESET in EXEC with a load pending: load lost
    step(1, 1, 2'd0, 10'h155, 10'h000, 0, 1, 10'h000, 0, 1, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h000, 0, 0, 0, 0); // INIT
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h000, 1, 0, 0, 0);
    step(0, 0, 2'd0, 10'h000, 10'h000, 0, 1, 10'h001, 0, 1, 0, 0);
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer for the RAT MCU. It owns the program counter and the fetch/execute/interrupt phase machine, and it drives the address input of the program ROM directly. The ROM shares the same clock and registers its output, so the instruction addressed during FETCH is valid during EXEC. The control unit consumes the phase outputs and supplies the load, mux and interrupt inputs.

## Interface
- ADDR_W, 10, program counter and ROM address width
- RESET_VEC, 10'h000, PC value loaded in INIT
- INTR_VEC, 10'h3FF, PC value loaded on interrupt entry
- CLK  in  1  system clock, shared with the program ROM
- RESET  in  1  synchronous, active-high reset
- PC_LD  in  1  load PC from the selected source; honoured only in EXEC
- PC_MUX_SEL  in  2  0 = FROM_IMMED, 1 = FROM_STACK, 2 = INTR_VEC, 3 = hold (load suppressed)
- FROM_IMMED  in  ADDR_W  branch/call target from the instruction
- FROM_STACK  in  ADDR_W  return address from the scratch stack
- INTR  in  1  external interrupt request, level
- IE  in  1  interrupt-enable flag from the flags block
- PC_COUNT  out  ADDR_W  current PC; drives the ROM address
- STATE_FETCH  out  1  high in FETCH
- STATE_EXEC  out  1  high in EXEC; the ROM output is a valid instruction
- INTR_ACK  out  1  high for the single INTR cycle
- INTR_PEND  out  1  latched interrupt request, visible for debug and flags

## Operation
- States: INIT, FETCH, EXEC, INTR. The encoding lives in the package.
- INIT:
  - PC <= RESET_VEC.
  - Clear the pending flag.
  - Next state is FETCH.
- FETCH:
  - The ROM samples PC_COUNT at the closing edge.
  - At the same edge, PC <= PC + 1 (mod 2^ADDR_W; 10'h3FF wraps to 10'h000).
  - Next state is EXEC.
- EXEC:
  - If PC_LD and PC_MUX_SEL != 3, PC <= the selected source. Otherwise PC holds.
  - If (pending or INTR) and IE, next state is INTR. Otherwise next state is FETCH.
- INTR:
  - PC_COUNT shows the return address: the already-incremented or loaded PC.
  - The control unit pushes this value during this cycle.
  - At the closing edge, PC <= INTR_VEC, the pending flag clears, and next state is FETCH.
- Pending flag:
  - Set on any cycle with INTR high.
  - Cleared only by INTR entry or RESET.
  - It is not gated by IE, so a request that arrives while IE = 0 is serviced once IE rises.
- PC_LD in FETCH, INTR or INIT is ignored.
- PC_MUX_SEL = 2 with PC_LD in EXEC gives a software jump to INTR_VEC. It does not assert INTR_ACK.

## Timing
- Reset values:
  - PC_COUNT = RESET_VEC.
  - State = INIT.
  - STATE_FETCH, STATE_EXEC, INTR_ACK and INTR_PEND are all 0.
- RESET is sampled at each edge. Asserting it in any state forces INIT at the next edge and discards any in-progress load or interrupt.
- Normal instruction: 2 cycles (FETCH, EXEC). Interrupt entry adds 1 cycle (INTR).
- The first instruction after reset is fetched in cycle 1 (INIT is cycle 0). It is valid in the EXEC cycle, cycle 2.
- Outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.
- Simultaneous PC_LD and interrupt in EXEC: the load applies first. The INTR cycle then shows the loaded target as the return address.
- INTR raised during FETCH is latched and taken at the following EXEC.

## Structure
- Package rat_pkg holds:
  - the fetch_state_t enum
  - the PC_MUX_SEL constants (PCSEL_IMMED, PCSEL_STACK, PCSEL_VEC, PCSEL_HOLD)
  - default RESET_VEC and INTR_VEC
- Sub-module program_counter holds the PC register, the increment, the 4:1 source mux, and the load/inc enables.
- fetch_unit contains the phase FSM and the pending latch, and instantiates program_counter.

## Test plan
- Reset then free-run, PC_LD = 0: PC_COUNT shows 0,0,1,1,2,2…. STATE_FETCH/STATE_EXEC alternate, starting with FETCH in cycle 1.
- In EXEC, PC_LD = 1, PC_MUX_SEL = 0, FROM_IMMED = 10'h155: the next FETCH presents 10'h155. Repeat with SEL = 1, FROM_STACK = 10'h2AA: the next FETCH presents 10'h2AA. Repeat with SEL = 3: the PC holds its incremented value.
- Load 10'h3FF, then run one FETCH: PC_COUNT wraps to 10'h000.
- IE = 1, INTR pulsed for 1 cycle during FETCH at PC 10'h020:
  - the INTR cycle follows the next EXEC, with PC_COUNT = 10'h021 and INTR_ACK = 1;
  - the next FETCH presents 10'h3FF;
  - INTR_PEND returns to 0.
- IE = 0 while INTR is pulsed: the machine stays in FETCH/EXEC and INTR_PEND stays 1. Raising IE later gives exactly one INTR entry.
- RESET asserted in the middle of EXEC with PC_LD = 1: the next cycle is INIT with PC_COUNT = 0 and all strobes 0, and the load is lost.
